// File: rtl/video_timing_pkg.sv
// Shared types and timing presets for the raster timing controller.
// Axis phase encoding plus XGA and VGA constant sets.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // 1024x768@60, 65 MHz
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FRONT  = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BACK   = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FRONT  = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BACK   = 29;

  // 640x480@60, 25.175 MHz
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping counter with its ACTIVE/FRONT/SYNC/BACK
// phase, both registered and always consistent with each other.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FRONT  = 24,
  parameter int SYNC   = 136,
  parameter int BACK   = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] count,
  output phase_t      phase,
  output logic        wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [15:0] LAST    = 16'(TOTAL - 1);
  localparam logic [15:0] B_FRONT = 16'(ACTIVE);
  localparam logic [15:0] B_SYNC  = 16'(ACTIVE + FRONT);
  localparam logic [15:0] B_BACK  = 16'(ACTIVE + FRONT + SYNC);

  logic [15:0] count_nx;
  phase_t      phase_nx;

  assign wrap = step && (count == LAST);

  // Next count and phase; the phase changes when the count lands on a boundary.
  always_comb begin
    count_nx = count;
    phase_nx = phase;
    if (step) begin
      count_nx = wrap ? 16'd0 : count + 16'd1;
      unique case (1'b1)
        count_nx == 16'd0:   phase_nx = PH_ACTIVE;
        count_nx == B_FRONT: phase_nx = PH_FRONT;
        count_nx == B_SYNC:  phase_nx = PH_SYNC;
        count_nx == B_BACK:  phase_nx = PH_BACK;
        default:             phase_nx = phase;
      endcase
    end
  end

  // Count and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
      phase <= PH_ACTIVE;
    end else begin
      count <= count_nx;
      phase <= phase_nx;
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing controller: x/y, visible, delayed syncs, line/frame markers.
// Syncs lag x/y by SYNC_DELAY clks to line up with registered pixel data.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = XGA_H_ACTIVE,
  parameter int   H_FRONT    = XGA_H_FRONT,
  parameter int   H_SYNC     = XGA_H_SYNC,
  parameter int   H_BACK     = XGA_H_BACK,
  parameter int   V_ACTIVE   = XGA_V_ACTIVE,
  parameter int   V_FRONT    = XGA_V_FRONT,
  parameter int   V_SYNC     = XGA_V_SYNC,
  parameter int   V_BACK     = XGA_V_BACK,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      H_TOTAL > 65535) begin : g_h_bad
    $error("video_timing: illegal horizontal timing");
  end
  if (V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      V_TOTAL > 65535) begin : g_v_bad
    $error("video_timing: illegal vertical timing");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_d_bad
    $error("video_timing: SYNC_DELAY must be 0..4");
  end

  phase_t h_ph;
  phase_t v_ph;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_step;
  logic   hs_raw;
  logic   vs_raw;

  assign v_step = h_wrap & pix_en;

  video_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk   (clk),
    .reset (reset),
    .step  (pix_en),
    .count (x),
    .phase (h_ph),
    .wrap  (h_wrap)
  );

  video_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk   (clk),
    .reset (reset),
    .step  (v_step),
    .count (y),
    .phase (v_ph),
    .wrap  (v_wrap)
  );

  // Reset forces visible low even though the counters sit at (0,0).
  assign visible = ~reset & (h_ph == PH_ACTIVE) & (v_ph == PH_ACTIVE);

  assign hs_raw = (h_ph == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign vs_raw = (v_ph == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;

  if (SYNC_DELAY == 0) begin : g_nodly
    assign hsync = hs_raw;
    assign vsync = vs_raw;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] hs_sr;
    logic [SYNC_DELAY-1:0] vs_sr;

    // Free-running sync delay line, independent of pix_en.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hs_sr <= {SYNC_DELAY{~HSYNC_POL}};
        vs_sr <= {SYNC_DELAY{~VSYNC_POL}};
      end else begin
        hs_sr <= (hs_sr << 1) | SYNC_DELAY'(hs_raw);
        vs_sr <= (vs_sr << 1) | SYNC_DELAY'(vs_raw);
      end
    end

    assign hsync = hs_sr[SYNC_DELAY-1];
    assign vsync = vs_sr[SYNC_DELAY-1];
  end

  // Markers pulse in the one cycle after a counter wrap actually happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: small 16x8 raster against a
// position-index model, plus line-level measurements on XGA defaults.
module tb_video_timing;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        pix_en_x = 1'b1;
  logic [15:0] x, y, xx, yx;
  logic        vis, hs, vs, ls, fs;
  logic        visx, hsx, vsx, lsx, fsx;

  int n_chk = 0;
  int n_fail = 0;

  // model: linear position in the 16x8 frame and previous position
  int mn = 0;

  always #5 clk = ~clk;

  video_timing #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .SYNC_DELAY (1)
  ) dut (
    .clk (clk), .reset (reset), .pix_en (pix_en),
    .x (x), .y (y), .visible (vis),
    .hsync (hs), .vsync (vs),
    .line_start (ls), .frame_start (fs)
  );

  video_timing dut_x (
    .clk (clk), .reset (reset), .pix_en (pix_en_x),
    .x (xx), .y (yx), .visible (visx),
    .hsync (hsx), .vsync (vsx),
    .line_start (lsx), .frame_start (fsx)
  );

  typedef struct {
    logic en;
    int   x;
    int   y;
    logic vis;
    logic ls;
    logic hs;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    mn = 0;
  endtask

  // One clk with the given enable, checked against the frame model.
  task automatic cyc(input logic en);
    int px, py, ex, ey;
    px = mn % 16;
    py = mn / 16;
    pix_en = en;
    @(posedge clk);
    #1;
    if (en) mn = (mn + 1) % 128;
    ex = mn % 16;
    ey = mn / 16;
    chk("x", 32'(x), 32'(ex));
    chk("y", 32'(y), 32'(ey));
    chk("visible", 32'(vis), 32'(ex < 8 && ey < 4));
    chk("line_start", 32'(ls), 32'(en && ex == 0));
    chk("frame_start", 32'(fs), 32'(en && mn == 0));
    chk("hsync", 32'(hs), 32'(!(px >= 10 && px <= 12)));
    chk("vsync", 32'(vs), 32'(!(py >= 5 && py <= 6)));
  endtask

  initial begin
    int t, f1, f2, run, hw, guard, l1, l2, vcnt, hx;
    logic hs_prev;

    tbl[0]  = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4, 0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 5, 0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 6, 0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 7, 0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8, 0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 9, 0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 10, 0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 11, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 11, 0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 12, 0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 13, 0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 14, 0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 15, 0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 0, 1, 1'b1, 1'b0, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_vis", 32'(vis), 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_ls", 32'(ls), 0);
    chk("rst_fs", 32'(fs), 0);
    #1 reset = 1'b0;
    #1;
    chk("rel_x", 32'(x), 0);
    chk("rel_vis", 32'(vis), 1);
    chk("rel_ls", 32'(ls), 0);

    // table vectors from (0,0)
    for (int i = 0; i < 19; i++) begin
      pix_en = tbl[i].en;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_x", i), 32'(x), 32'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_vis", i), 32'(vis), 32'(tbl[i].vis));
      chk($sformatf("tbl%0d_ls", i), 32'(ls), 32'(tbl[i].ls));
      chk($sformatf("tbl%0d_hs", i), 32'(hs), 32'(tbl[i].hs));
    end

    // randomized enable against the model
    do_reset();
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0);

    // alternating enable: frame period and hsync width
    t = 0; f1 = -1; f2 = -1; run = 0; hw = -1;
    hs_prev = 1'b1;
    while (f2 < 0 && t < 700) begin
      cyc(t[0] == 1'b0);
      t++;
      if (fs) begin
        if (f1 < 0) f1 = t;
        else f2 = t;
      end
      if (f1 >= 0) begin
        if (!hs) run++;
        else if (!hs_prev && hw < 0) hw = run;
        if (hs) run = 0;
      end
      hs_prev = hs;
    end
    chk("toggle_frame_clks", 32'(f2 - f1), 256);
    chk("toggle_hsync_clks", 32'(hw), 6);

    // simultaneous x/y wrap
    guard = 0;
    while (mn != 127 && guard < 200) begin
      cyc(1'b1);
      guard++;
    end
    chk("reach_corner", 32'(mn), 127);
    cyc(1'b1);
    chk("wrap_x", 32'(x), 0);
    chk("wrap_y", 32'(y), 0);
    chk("wrap_ls", 32'(ls), 1);
    chk("wrap_fs", 32'(fs), 1);
    cyc(1'b0);
    chk("hold_ls", 32'(ls), 0);
    chk("hold_fs", 32'(fs), 0);

    // asynchronous reset mid-line
    do_reset();
    for (int i = 0; i < 37; i++) cyc(1'b1);
    chk("pre_x", 32'(x), 5);
    chk("pre_y", 32'(y), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_x", 32'(x), 0);
    chk("async_y", 32'(y), 0);
    chk("async_vis", 32'(vis), 0);
    chk("async_hs", 32'(hs), 1);
    chk("async_vs", 32'(vs), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    mn = 0;
    #1;
    chk("after_x", 32'(x), 0);
    chk("after_y", 32'(y), 0);
    cyc(1'b1);
    cyc(1'b1);

    // XGA defaults: line period, hsync width/position, visible per line
    reset = 1'b1;
    pix_en_x = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    l1 = -1; l2 = -1; vcnt = 0; run = 0; hw = -1; hx = -1;
    hs_prev = 1'b1;
    for (int i = 1; i <= 3000 && l2 < 0; i++) begin
      @(posedge clk);
      #1;
      if (lsx) begin
        chk("xga_ls_x", 32'(xx), 0);
        if (l1 < 0) l1 = i;
        else l2 = i;
      end
      if (l1 >= 0 && l2 < 0 && visx) vcnt++;
      if (!hsx && hs_prev && hx < 0) hx = int'(xx);
      if (!hsx) run++;
      else if (!hs_prev && hw < 0) hw = run;
      if (hsx) run = 0;
      hs_prev = hsx;
    end
    chk("xga_first_ls", 32'(l1), 1344);
    chk("xga_line_clks", 32'(l2 - l1), 1344);
    chk("xga_y_line2", 32'(yx), 2);
    chk("xga_vis_line", 32'(vcnt), 1024);
    chk("xga_hsync_clks", 32'(hw), 136);
    chk("xga_hsync_x", 32'(hx), 1049);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
